// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Magnitude shift-add multiplier / restoring divider sharing one hi/lo register pair,
// plus the sign-fixup and special-case result mux.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            fix_i,
  input  logic            fast_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic [XLEN-1:0] result_o
);

  logic [2:0]      f3_q;
  logic            sa_q, sb_q, bz_q;
  logic [XLEN-1:0] a_orig_q, m_q, hi_q, lo_q, result_q;

  logic            a_signed, b_signed, sa_in, sb_in, is_div_in;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;
  logic [XLEN-1:0] hi_d, lo_d, fix_res;
  logic [XLEN:0]   add_sum, rsh;
  logic [XLEN-1:0] diff;
  logic            ge;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3_i)
      OP_MULH, OP_DIV, OP_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
      OP_MULHSU:               a_signed = 1'b1;
      default: ;
    endcase
  end

  assign sa_in     = a_signed & op_a_i[XLEN-1];
  assign sb_in     = b_signed & op_b_i[XLEN-1];
  assign mag_a     = sa_in ? (~op_a_i + 1'b1) : op_a_i;
  assign mag_b     = sb_in ? (~op_b_i + 1'b1) : op_b_i;
  assign is_div_in = funct3_i[2];

  // Zero-operand shortcut: REM of a zero dividend is the dividend itself, same as rem-by-zero.
  assign fast_res = !funct3_i[2] ? '0 :
                    funct3_i[1]  ? op_a_i :
                    (op_b_i == '0) ? '1 : '0;

  assign add_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : '0)};
  assign rsh     = {hi_q, lo_q[XLEN-1]};
  assign ge      = rsh >= {1'b0, m_q};
  assign diff    = rsh[XLEN-1:0] - m_q;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (f3_q[2]) begin
      hi_d = ge ? diff : rsh[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ge};
    end else begin
      hi_d = add_sum[XLEN:1];
      lo_d = {add_sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign prod     = {hi_q, lo_q};
  assign prod_fix = (sa_q ^ sb_q) ? (~prod + 1'b1) : prod;
  assign quot_fix = (sa_q ^ sb_q) ? (~lo_q + 1'b1) : lo_q;
  assign rem_fix  = sa_q ? (~hi_q + 1'b1) : hi_q;

  always_comb begin
    fix_res = '0;
    case (f3_q)
      OP_MUL:                         fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                fix_res = bz_q ? '1 : quot_fix;
      OP_REM, OP_REMU:                fix_res = bz_q ? a_orig_q : rem_fix;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      a_orig_q <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else if (load_i) begin
      f3_q     <= funct3_i;
      sa_q     <= sa_in;
      sb_q     <= sb_in;
      bz_q     <= (op_b_i == '0);
      a_orig_q <= op_a_i;
      hi_q     <= '0;
      lo_q     <= is_div_in ? mag_a : mag_b;
      m_q      <= is_div_in ? mag_b : mag_a;
      if (fast_i) result_q <= fast_res;
    end else if (step_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end else if (fix_i) begin
      result_q <= fix_res;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: IDLE -> CALC(32) -> FIXUP -> DONE, one writeback pulse.
// Define MULDIV_FAST_ZERO_EN to finish zero-operand requests straight from IDLE.
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(CYCLES);

  muldiv_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rd_q, rd_out_q;
  logic          accept, fast_zero, last_iter;

`ifdef MULDIV_FAST_ZERO_EN
  assign fast_zero = (op_a == '0) || (op_b == '0);
`else
  assign fast_zero = 1'b0;
`endif

  assign accept    = (state_q == ST_IDLE) && start;
  assign last_iter = (cnt_q == CW'(CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = fast_zero ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (last_iter) state_d = ST_FIXUP;
      end
      ST_FIXUP: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) rd_q <= rd_in;
      if (state_q == ST_FIXUP)    rd_out_q <= rd_q;
      else if (accept && fast_zero) rd_out_q <= rd_in;
    end
  end

  muldiv_datapath u_dp (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .step_i   (state_q == ST_CALC),
    .fix_i    (state_q == ST_FIXUP),
    .fast_i   (accept && fast_zero),
    .funct3_i (funct3),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .result_o (result)
  );

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign rd_out = rd_out_q;
  assign we     = done && (rd_out_q != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver queues expected writebacks, monitor checks each done.
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
`ifdef MULDIV_FAST_ZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, we;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[16] = '{
    '{F_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 34},
    '{F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 34},
    '{F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 34},
    '{F_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd4,  32'hFFFF_FFFD, 34},
    '{F_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, 34},
    '{F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 34},
    '{F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 34},
    '{F_DIVU,   32'h0000_0005, 32'h0000_0000, 5'd12, 32'hFFFF_FFFF, ZLAT},
    '{F_REMU,   32'h0000_0005, 32'h0000_0000, 5'd13, 32'h0000_0005, ZLAT},
    '{F_DIVU,   32'h0000_0064, 32'h0000_0007, 5'd14, 32'h0000_000E, 34},
    '{F_REMU,   32'h0000_0064, 32'h0000_0007, 5'd15, 32'h0000_0002, 34},
    '{F_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'h0000_0001, 34},
    '{F_REM,    32'h0000_0007, 32'hFFFF_FFFE, 5'd17, 32'h0000_0001, 34},
    '{F_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 5'd18, 32'hFFFF_FFFD, 34},
    '{F_DIV,    32'h0000_0000, 32'h0000_0005, 5'd20, 32'h0000_0000, ZLAT},
    '{F_MUL,    32'h0000_0000, 32'h0000_007B, 5'd21, 32'h0000_0000, ZLAT}
  };

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .we     (we)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Caller sits on a negedge; returns on the negedge of relative cycle 1.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat,
                       input bit expect_done, output int t0);
    int guard;
    exp_t e;
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("idle_before_start", {31'd0, busy}, 32'd0);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    t0     = cyc;
    if (expect_done) begin
      e.res = res;
      e.rd  = rd;
      e.we  = (rd != 5'd0);
      e.due = t0 + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start  = 1'b0;
    funct3 = ~f;
    op_a   = ~a;
    op_b   = ~b;
    rd_in  = ~rd;
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=1 with result %h rd_out %0d, expected no done (cycle %0d)",
                 result, rd_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
        check("we", {31'd0, we}, {31'd0, e.we});
        check("done_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, guard;
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);
    check("reset_we",     {31'd0, we},   32'd0);
    check("reset_result", result,        32'd0);
    check("reset_rd_out", {27'd0, rd_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // MUL 7 * -3 with busy window checks
    issue(F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 34, 1'b1, t0);
    check("busy_cycle1", {31'd0, busy}, 32'd1);
    while (cyc < t0 + 34) @(negedge clk);
    check("busy_cycle34", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("idle_cycle35", {31'd0, busy}, 32'd0);

    foreach (vecs[i])
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res, vecs[i].lat, 1'b1, t0);

    // start pulses while busy must be ignored
    issue(F_MUL, 32'd3, 32'd4, 5'd6, 32'd12, 34, 1'b1, t0);
    while (cyc < t0 + 10) @(negedge clk);
    start = 1'b1; funct3 = F_DIVU; op_a = 32'd9; op_b = 32'd3; rd_in = 5'd7;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 34) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // rd = 0: done without write enable
    issue(F_MUL, 32'd2, 32'd3, 5'd0, 32'd6, 34, 1'b1, t0);

    // reset in the middle of a divide, then a clean restart
    issue(F_DIV, 32'd100, 32'd7, 5'd9, 32'd0, 34, 1'b0, t0);
    while (cyc < t0 + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(F_DIV, 32'd100, 32'd7, 5'd9, 32'd14, 34, 1'b1, t1);

    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (40) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
